// File: rtl/mold_seq_pkg.sv
// Shared types and width defaults for the MoldUDP64 sequence tracker.
package mold_seq_pkg;

    localparam int DEF_SEQ_W = 64;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_SID_W = 80;

    typedef enum logic [1:0] {
        ST_UNSYNC   = 2'd0,
        ST_SYNC     = 2'd1,
        ST_GAP_WAIT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        DEC_ACCEPT    = 3'd0,
        DEC_PARTIAL   = 3'd1,
        DEC_DUP       = 3'd2,
        DEC_GAP       = 3'd3,
        DEC_MISMATCH  = 3'd4,
        DEC_HEARTBEAT = 3'd5,
        DEC_MALFORMED = 3'd6
    } decision_t;

endpackage

// File: rtl/mold_seq_stats.sv
// Wrapping 32-bit event counters for duplicate drops, issued gap requests
// and session mismatches.
module mold_seq_stats (
    input  logic        clk,
    input  logic        rst,
    input  logic        dup_inc,
    input  logic        gap_inc,
    input  logic        mismatch_inc,
    output logic [31:0] dup_cnt,
    output logic [31:0] gap_cnt,
    output logic [31:0] mismatch_cnt
);

    // Count each event class; counters wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dup_cnt      <= 32'd0;
            gap_cnt      <= 32'd0;
            mismatch_cnt <= 32'd0;
        end else begin
            if (dup_inc) begin
                dup_cnt <= dup_cnt + 32'd1;
            end
            if (gap_inc) begin
                gap_cnt <= gap_cnt + 32'd1;
            end
            if (mismatch_inc) begin
                mismatch_cnt <= mismatch_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/mold_seq_tracker.sv
// MoldUDP64 sequence tracker: classifies each packet header as accept,
// partial accept or drop, tracks the next expected sequence and issues
// retransmission requests over a valid/ready handshake.
// Optional statistics counters are enabled with MOLD_SEQ_STATS_EN.
module mold_seq_tracker
    import mold_seq_pkg::*;
#(
    parameter int SEQ_W = DEF_SEQ_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int SID_W = DEF_SID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hdr_valid,
    input  logic [SID_W-1:0] session_id,
    input  logic [SEQ_W-1:0] sequence_number,
    input  logic [CNT_W-1:0] message_count,
    output logic             pkt_accept,
    output logic             pkt_drop,
    output logic [CNT_W-1:0] skip_count,
    output logic             session_mismatch,
    output logic             gap_req_valid,
    input  logic             gap_req_ready,
    output logic [SEQ_W-1:0] gap_req_seq,
    output logic [CNT_W-1:0] gap_req_count,
    output logic [SEQ_W-1:0] expected_seq,
    output logic             synced
`ifdef MOLD_SEQ_STATS_EN
    ,
    output logic [31:0]      dup_cnt,
    output logic [31:0]      gap_cnt,
    output logic [31:0]      mismatch_cnt
`endif
);

    state_t           state_r;
    state_t           state_next_s;
    logic [SID_W-1:0] sid_r;
    logic [SID_W-1:0] sid_next_s;

    logic             accept_s;
    logic             drop_s;
    logic             mismatch_s;
    logic [CNT_W-1:0] skip_s;
    logic [SEQ_W-1:0] exp_next_s;
    logic             synced_next_s;
    logic             gap_valid_next_s;
    logic [SEQ_W-1:0] gap_seq_next_s;
    logic [CNT_W-1:0] gap_cnt_next_s;
    decision_t        decision_s;

    logic [SEQ_W:0]   end_s;
    logic [SEQ_W-1:0] gap_diff_s;
    logic [SEQ_W-1:0] skip_full_s;
    logic [CNT_W-1:0] gap_sat_s;
    logic             handshake_s;
    logic             seq_gt_s;
    logic             seq_eq_s;
    logic             end_gt_s;
    logic             is_hb_s;

    // Header arithmetic: packet end in SEQ_W+1 bits so overflow is visible,
    // plus unsigned comparisons against the expected sequence.
    always_comb begin
        end_s       = {1'b0, sequence_number} + {{(SEQ_W + 1 - CNT_W){1'b0}}, message_count};
        gap_diff_s  = sequence_number - expected_seq;
        skip_full_s = expected_seq - sequence_number;
        seq_gt_s    = (sequence_number > expected_seq);
        seq_eq_s    = (sequence_number == expected_seq);
        end_gt_s    = (end_s > {1'b0, expected_seq});
        is_hb_s     = (message_count == {CNT_W{1'b0}});
        handshake_s = gap_req_valid && gap_req_ready;
        if (|gap_diff_s[SEQ_W-1:CNT_W]) begin
            gap_sat_s = {CNT_W{1'b1}};
        end else begin
            gap_sat_s = gap_diff_s[CNT_W-1:0];
        end
    end

    // Next-state and decision logic for the tracker FSM.
    always_comb begin
        state_next_s     = state_r;
        sid_next_s       = sid_r;
        accept_s         = 1'b0;
        drop_s           = 1'b0;
        mismatch_s       = 1'b0;
        skip_s           = {CNT_W{1'b0}};
        exp_next_s       = expected_seq;
        synced_next_s    = synced;
        gap_valid_next_s = gap_req_valid;
        gap_seq_next_s   = gap_req_seq;
        gap_cnt_next_s   = gap_req_count;
        decision_s       = DEC_HEARTBEAT;

        // A completed handshake retires the pending request first; a gapped
        // header in the same cycle may then re-arm it below.
        if ((state_r == ST_GAP_WAIT) && handshake_s) begin
            gap_valid_next_s = 1'b0;
            state_next_s     = ST_SYNC;
        end else begin
            gap_valid_next_s = gap_req_valid;
        end

        if (hdr_valid) begin
            case (state_r)
                ST_UNSYNC: begin
                    if (end_s[SEQ_W]) begin
                        decision_s = DEC_MALFORMED;
                        drop_s     = 1'b1;
                    end else begin
                        decision_s    = is_hb_s ? DEC_HEARTBEAT : DEC_ACCEPT;
                        accept_s      = 1'b1;
                        sid_next_s    = session_id;
                        exp_next_s    = end_s[SEQ_W-1:0];
                        synced_next_s = 1'b1;
                        state_next_s  = ST_SYNC;
                    end
                end
                ST_SYNC, ST_GAP_WAIT: begin
                    if (end_s[SEQ_W]) begin
                        decision_s = DEC_MALFORMED;
                        drop_s     = 1'b1;
                    end else if (session_id != sid_r) begin
                        decision_s = DEC_MISMATCH;
                        drop_s     = 1'b1;
                        mismatch_s = 1'b1;
                    end else if (seq_gt_s) begin
                        decision_s = DEC_GAP;
                        drop_s     = 1'b1;
                        if ((state_r == ST_SYNC) || handshake_s) begin
                            gap_valid_next_s = 1'b1;
                            gap_seq_next_s   = expected_seq;
                            gap_cnt_next_s   = gap_sat_s;
                            state_next_s     = ST_GAP_WAIT;
                        end else begin
                            gap_valid_next_s = gap_req_valid;
                        end
                    end else if (is_hb_s) begin
                        decision_s = DEC_HEARTBEAT;
                        drop_s     = 1'b1;
                    end else if (seq_eq_s) begin
                        decision_s = DEC_ACCEPT;
                        accept_s   = 1'b1;
                        exp_next_s = end_s[SEQ_W-1:0];
                    end else if (end_gt_s) begin
                        decision_s = DEC_PARTIAL;
                        accept_s   = 1'b1;
                        skip_s     = skip_full_s[CNT_W-1:0];
                        exp_next_s = end_s[SEQ_W-1:0];
                    end else begin
                        decision_s = DEC_DUP;
                        drop_s     = 1'b1;
                    end
                end
                default: begin
                    state_next_s = ST_UNSYNC;
                    drop_s       = 1'b1;
                end
            endcase
        end else begin
            decision_s = DEC_HEARTBEAT;
        end
    end

    // State, latched session and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r          <= ST_UNSYNC;
            sid_r            <= {SID_W{1'b0}};
            pkt_accept       <= 1'b0;
            pkt_drop         <= 1'b0;
            skip_count       <= {CNT_W{1'b0}};
            session_mismatch <= 1'b0;
            gap_req_valid    <= 1'b0;
            gap_req_seq      <= {SEQ_W{1'b0}};
            gap_req_count    <= {CNT_W{1'b0}};
            expected_seq     <= {SEQ_W{1'b0}};
            synced           <= 1'b0;
        end else begin
            state_r          <= state_next_s;
            sid_r            <= sid_next_s;
            pkt_accept       <= accept_s;
            pkt_drop         <= drop_s;
            skip_count       <= skip_s;
            session_mismatch <= mismatch_s;
            gap_req_valid    <= gap_valid_next_s;
            gap_req_seq      <= gap_seq_next_s;
            gap_req_count    <= gap_cnt_next_s;
            expected_seq     <= exp_next_s;
            synced           <= synced_next_s;
        end
    end

`ifdef MOLD_SEQ_STATS_EN
    logic dup_inc_s;
    logic gap_inc_s;
    logic mismatch_inc_s;

    // Event pulses for the statistics counters.
    always_comb begin
        dup_inc_s      = hdr_valid && (decision_s == DEC_DUP);
        mismatch_inc_s = hdr_valid && (decision_s == DEC_MISMATCH);
        gap_inc_s      = hdr_valid && (decision_s == DEC_GAP) &&
                         ((state_r == ST_SYNC) || handshake_s);
    end

    mold_seq_stats u_stats (
        .clk          (clk),
        .rst          (rst),
        .dup_inc      (dup_inc_s),
        .gap_inc      (gap_inc_s),
        .mismatch_inc (mismatch_inc_s),
        .dup_cnt      (dup_cnt),
        .gap_cnt      (gap_cnt),
        .mismatch_cnt (mismatch_cnt)
    );
`endif

endmodule

// File: doc/mold_seq_tracker.md
# mold_seq_tracker

Sequence controller for the ITCH receive path. It takes the MoldUDP64 header fields from the parser (session, sequence number, message count) once per packet and decides whether the packet's messages are accepted, partially skipped or dropped. It tracks the next expected sequence number and raises a retransmission (gap) request over a valid/ready handshake. It sits between the header parser and the message dispatcher.

## Interface
- SEQ_W, 64, sequence-number width
- CNT_W, 16, message-count width
- SID_W, 80, session-ID width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- hdr_valid  in  1  one-cycle strobe; header fields valid this cycle
- session_id  in  SID_W  MoldUDP64 session
- sequence_number  in  SEQ_W  first message sequence of packet
- message_count  in  CNT_W  messages in packet (0 = heartbeat)
- pkt_accept  out  1  strobe: forward packet messages
- pkt_drop  out  1  strobe: discard whole packet
- skip_count  out  CNT_W  leading messages to discard; valid with pkt_accept
- session_mismatch  out  1  strobe: session differs from latched session
- gap_req_valid  out  1  retransmission request pending
- gap_req_ready  in  1  consumer accepts request
- gap_req_seq  out  SEQ_W  first missing sequence
- gap_req_count  out  CNT_W  missing messages, saturated at 2^CNT_W-1
- expected_seq  out  SEQ_W  next expected sequence
- synced  out  1  session latched

## Operation
- States: UNSYNC, SYNC, GAP_WAIT.
- UNSYNC, hdr_valid: latch session_id, expected_seq = seq+count, pkt_accept, skip_count 0 → SYNC. A heartbeat also latches, with expected_seq = seq.
- SYNC/GAP_WAIT, hdr_valid. Let end = seq+count, computed in SEQ_W+1 bits:
  - end overflows SEQ_W → pkt_drop, no change.
  - session_id ≠ latched → pkt_drop and session_mismatch, no change.
  - count = 0 → pkt_drop. If seq > expected, treat as a gap.
  - seq = expected → pkt_accept, skip 0, expected = end.
  - seq < expected < end → pkt_accept, skip = expected−seq, expected = end.
  - end ≤ expected → pkt_drop (duplicate).
  - seq > expected → pkt_drop. In SYNC: load gap_req_seq = expected, gap_req_count = min(seq−expected, 2^CNT_W−1), assert gap_req_valid → GAP_WAIT. In GAP_WAIT: no new request.
- GAP_WAIT: gap_req_valid && gap_req_ready → deassert valid → SYNC. In-order retransmitted packets are accepted while waiting.
- A handshake and a gapped header in the same cycle complete the old request. The new request appears next cycle and valid stays high.
- All comparisons are unsigned. Exactly one of pkt_accept/pkt_drop fires per hdr_valid.

## Timing
- Reset: state UNSYNC; all outputs 0, including expected_seq, gap fields and the latched session.
- Decision outputs are registered: 1 cycle after hdr_valid, high for exactly 1 cycle.
- expected_seq and synced update in the same cycle as the decision strobe.
- hdr_valid may assert every cycle; throughput is 1 header/cycle.
- gap_req_seq and gap_req_count hold stable while gap_req_valid && !gap_req_ready.
- Reset mid-operation abandons any pending request immediately.

## Configuration
- MOLD_SEQ_STATS_EN defined adds outputs dup_cnt, gap_cnt and mismatch_cnt, each 32 bits, wrapping, reset 0:
  - dup_cnt increments once per duplicate drop.
  - gap_cnt increments once per gap request issued.
  - mismatch_cnt increments once per session_mismatch.
- MOLD_SEQ_STATS_EN undefined: these ports and counters are absent and decision behaviour is identical.

## Structure
- mold_seq_pkg holds:
  - state enum (UNSYNC, SYNC, GAP_WAIT);
  - SEQ_W, CNT_W and SID_W defaults;
  - decision-code enum (ACCEPT, PARTIAL, DUP, GAP, MISMATCH, HEARTBEAT, MALFORMED).
- One sub-module, mold_seq_stats, holds the three counters and is instantiated only under MOLD_SEQ_STATS_EN.

## Test plan
- Reset, then header seq=1, count=3 → pkt_accept, skip 0, synced=1, expected_seq=4.
- Next seq=4, count=2 → accept, expected=6. Then seq=5, count=3 → accept, skip_count=1, expected=8.
- Next seq=20, count=1 → pkt_drop, gap_req_valid with seq=8, count=12. Hold gap_req_ready=0 for 3 cycles: fields stable. Then ready=1 → valid drops → SYNC.
- In GAP_WAIT, header seq=8, count=12 → accept, expected=20. Header seq=3, count=2 → pkt_drop (duplicate), dup_cnt+1 when MOLD_SEQ_STATS_EN is defined.
- Header with a different session_id → pkt_drop plus session_mismatch, expected unchanged.
- Assert rst mid-GAP_WAIT → all outputs 0, UNSYNC; next header re-syncs.
